// File: rtl/key_arb_pkg.sv
// Shared types and helpers for the key-path arbiter.
package key_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  localparam int unsigned KEY_W_DEF  = 56;
  localparam int unsigned TRIG_W_DEF = 32;

  // Index width for n items; never narrower than one bit
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_path_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_pick
  import key_arb_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = id_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] cand;

  // Scan ptr, ptr+1, ... modulo N and keep the first hit
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (ID_W + 1)'(k);
      if (sum >= (ID_W + 1)'(N)) begin
        sum = sum - (ID_W + 1)'(N);
      end
      cand = ID_W'(sum);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_path_arbiter.sv
// Round-robin sequencer sharing one fixed-latency key datapath among requesters.
module key_path_arbiter
  import key_arb_pkg::*;
#(
  parameter int unsigned        NUM_REQ   = 4,
  parameter int unsigned        KEY_W     = KEY_W_DEF,
  parameter int unsigned        TRIG_W    = TRIG_W_DEF,
  parameter int unsigned        LAT       = 1,
  parameter logic [TRIG_W-1:0]  IDLE_TRIG = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*KEY_W-1:0]      req_key,
  input  logic [NUM_REQ*TRIG_W-1:0]     req_trig,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [KEY_W-1:0]              dp_key,
  output logic [TRIG_W-1:0]             dp_trigger,
  input  logic [KEY_W-1:0]              dp_payload,
  output logic                          resp_valid,
  output logic [id_w(NUM_REQ)-1:0]      resp_id,
  output logic [KEY_W-1:0]              resp_payload
);

  localparam int unsigned ID_W  = id_w(NUM_REQ);
  localparam int unsigned CNT_W = id_w(LAT + 1);

  arb_state_t         state, state_d;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_d;
  logic [ID_W-1:0]    gnt_id, gnt_id_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [KEY_W-1:0]   dp_key_d;
  logic [TRIG_W-1:0]  dp_trigger_d;
  logic               resp_valid_d;
  logic [ID_W-1:0]    resp_id_d;
  logic [KEY_W-1:0]   resp_payload_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic [KEY_W-1:0]   sel_key;
  logic [TRIG_W-1:0]  sel_trig;
  logic               accept;

  rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Grant strobe is live only while idle and out of reset
  assign accept    = (state == IDLE) && pick_any && !rst;
  assign req_ready = accept ? pick_gnt : '0;

  // Select the granted requester's key/trigger slices
  always_comb begin
    sel_key  = '0;
    sel_trig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_key  = req_key[i*KEY_W +: KEY_W];
        sel_trig = req_trig[i*TRIG_W +: TRIG_W];
      end
    end
  end

  // Next-state and datapath/response next values
  always_comb begin
    state_d        = state;
    rr_ptr_d       = rr_ptr;
    gnt_id_d       = gnt_id;
    cnt_d          = cnt;
    dp_key_d       = dp_key;
    dp_trigger_d   = dp_trigger;
    resp_valid_d   = 1'b0;
    resp_id_d      = resp_id;
    resp_payload_d = resp_payload;
    case (state)
      IDLE: begin
        if (accept) begin
          dp_key_d     = sel_key;
          dp_trigger_d = sel_trig;
          gnt_id_d     = pick_idx;
          cnt_d        = CNT_W'(LAT);
          state_d      = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          resp_payload_d = dp_payload;
          resp_id_d      = gnt_id;
          resp_valid_d   = 1'b1;
          rr_ptr_d       = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
          dp_trigger_d   = IDLE_TRIG;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gnt_id       <= '0;
      cnt          <= '0;
      dp_key       <= '0;
      dp_trigger   <= IDLE_TRIG;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_payload <= '0;
    end else begin
      state        <= state_d;
      rr_ptr       <= rr_ptr_d;
      gnt_id       <= gnt_id_d;
      cnt          <= cnt_d;
      dp_key       <= dp_key_d;
      dp_trigger   <= dp_trigger_d;
      resp_valid   <= resp_valid_d;
      resp_id      <= resp_id_d;
      resp_payload <= resp_payload_d;
    end
  end

endmodule
